// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-to-binary decoder and its step monitor.
package gray_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

    localparam int GRAY_MAX_W = 64;

    // Zero-extended upper bits decode to zero, so one wide function serves any WIDTH.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin_decoder_if.sv
// Bus between a Gray sample producer/result consumer and the decoder.
// Handshake: a beat moves on a stage boundary in any cycle where valid and ready are both 1 at the rising edge.
interface gray_to_bin_decoder_if
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic             out_step_err;
    logic             err_clear;
    logic             step_err;
    logic [CNT_W-1:0] err_count;
    mon_state_t       mon_state;

    modport master (
        output in_valid, in_gray, out_ready, err_clear,
        input  in_ready, out_valid, out_bin, out_step_err, step_err, err_count, mon_state
    );

    modport slave (
        input  in_valid, in_gray, out_ready, err_clear,
        output in_ready, out_valid, out_bin, out_step_err, step_err, err_count, mon_state
    );
endinterface

// File: rtl/gray_step_checker.sv
// Tracks the last accepted Gray code and flags any accepted code that is not a single-bit step.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit ALLOW_REPEAT = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] gray,
    input  logic             err_clear,
    output logic             beat_err,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count,
    output mon_state_t       state
);
    mon_state_t       state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] diff;
    logic             step_d;
    logic [CNT_W-1:0] cnt_d;

    assign diff = gray ^ prev_q;

    always_comb begin
        state_d  = state;
        prev_d   = prev_q;
        beat_err = 1'b0;
        if (accept) prev_d = gray;
        // A clear forgets history, so a same-cycle beat starts fresh tracking.
        if (err_clear) begin
            state_d = accept ? TRACK : IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    state_d = TRACK;
                TRACK:   beat_err = ($countones(diff) > 1) || ((diff == '0) && !ALLOW_REPEAT);
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        step_d = step_err;
        cnt_d  = err_count;
        if (err_clear) begin
            step_d = 1'b0;
            cnt_d  = '0;
        end else if (beat_err) begin
            step_d = 1'b1;
            if (err_count != '1) cnt_d = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev_q    <= '0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            prev_q    <= prev_d;
            step_err  <= step_d;
            err_count <= cnt_d;
        end
    end
endmodule

// File: rtl/gray_to_bin_decoder.sv
// Two-stage elastic Gray-to-binary decoder with a one-bit-step monitor on accepted samples.
module gray_to_bin_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit ALLOW_REPEAT = 1'b1,
    parameter int CNT_W        = 8
) (
    input logic                    clk,
    input logic                    rst,
    gray_to_bin_decoder_if.slave   bus
);
    logic             s1_valid;
    logic             s1_err;
    logic [WIDTH-1:0] s1_gray;
    logic             s2_valid;
    logic             s2_err;
    logic [WIDTH-1:0] s2_bin;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    logic             beat_err;
    logic [WIDTH-1:0] dec_bin;

    assign s2_adv  = !s2_valid || bus.out_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign accept  = bus.in_valid && s1_adv;
    assign dec_bin = WIDTH'(gray2bin(GRAY_MAX_W'(s1_gray)));

    gray_step_checker #(
        .WIDTH        (WIDTH),
        .ALLOW_REPEAT (ALLOW_REPEAT),
        .CNT_W        (CNT_W)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .gray      (bus.in_gray),
        .err_clear (bus.err_clear),
        .beat_err  (beat_err),
        .step_err  (bus.step_err),
        .err_count (bus.err_count),
        .state     (bus.mon_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_gray  <= '0;
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_bin   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (accept) begin
                    s1_gray <= bus.in_gray;
                    s1_err  <= beat_err;
                end
            end
            // Payload registers only load on real beats so held outputs never glitch.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_bin <= dec_bin;
                    s2_err <= s1_err;
                end
            end
        end
    end

    assign bus.in_ready     = s1_adv;
    assign bus.out_valid    = s2_valid;
    assign bus.out_bin      = s2_bin;
    assign bus.out_step_err = s2_err;
endmodule

// File: tb/tb_gray_to_bin_decoder.sv
// Scoreboard bench for gray_to_bin_decoder: directed scenarios plus randomized beats against a table-based model.
module tb_gray_to_bin_decoder;
    import gray_pkg::*;

    localparam int W       = 4;
    localparam bit AR      = 1'b1;
    localparam int CNT_MAX = 255;
    localparam bit AR2     = 1'b0;
    localparam int CNT2_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_to_bin_decoder_if #(.WIDTH(W), .CNT_W(8)) bus ();
    gray_to_bin_decoder_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

    gray_to_bin_decoder #(.WIDTH(W), .ALLOW_REPEAT(AR), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gray_to_bin_decoder #(.WIDTH(W), .ALLOW_REPEAT(AR2), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reflected Gray code of n, and its inverse found by table search.
    function automatic logic [W-1:0] to_gray(input int n);
        int v;
        v = n ^ (n >> 1);
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++) begin
            if (to_gray(b) == g) return b[W-1:0];
        end
        return '0;
    endfunction

    logic [W:0] exp_q[$];
    int         stamp_q[$];
    int         cyc    = 0;
    bit         lat_on = 1'b0;
    bit         m_track = 1'b0;
    logic [W-1:0] m_prev = '0;
    int         m_cnt    = 0;
    bit         m_sticky = 1'b0;
    bit         held     = 1'b0;
    logic [W:0] held_val = '0;
    int         acc_cnt  = 0;
    int         ready_mode = 1;

    // Monitor: checks sticky state, held outputs, and pops expected beats; then advances the model.
    always @(negedge clk) begin
        logic [W:0] e;
        int         s;
        int         d;
        bit         err;
        cyc++;
        if (rst) begin
            held = 1'b0;
        end else begin
            check("step_err", 32'(bus.step_err), 32'(m_sticky));
            check("err_count", 32'(bus.err_count), 32'(m_cnt));
            if (held) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold", 32'({bus.out_step_err, bus.out_bin}), 32'(held_val));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got bin %0h err %0b, expected no beat", bus.out_bin, bus.out_step_err);
                end else begin
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
                    check("out_beat", 32'({bus.out_step_err, bus.out_bin}), 32'(e));
                    if (lat_on) check("latency", 32'(cyc - s), 32'd2);
                end
            end
            held     = bus.out_valid && !bus.out_ready;
            held_val = {bus.out_step_err, bus.out_bin};

            if (bus.err_clear) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
                m_track  = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                err = 1'b0;
                if (m_track) begin
                    d   = $countones(bus.in_gray ^ m_prev);
                    err = (d > 1) || (d == 0 && !AR);
                end
                if (err) begin
                    m_sticky = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
                m_prev  = bus.in_gray;
                m_track = 1'b1;
                exp_q.push_back({err, ref_bin(bus.in_gray)});
                stamp_q.push_back(cyc);
            end
        end
    end

    int acc2 = 0;
    int out2 = 0;
    int err2 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus2.in_valid && bus2.in_ready) acc2++;
            if (bus2.out_valid && bus2.out_ready) begin
                out2++;
                if (bus2.out_step_err) err2++;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input logic [W-1:0] g, input bit clr);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_gray   = g;
        bus.err_clear = clr;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            bus.err_clear = 1'b0;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 for 100 cycles, expected 1");
        end
    endtask

    task automatic pulse_clear();
        bus.err_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clear = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && (exp_q.size() != 0 || bus.out_valid); i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int start;
        int cur;
        int r;
        int exp_e;
        bit ok;
        bus.in_valid   = 1'b0;
        bus.in_gray    = '0;
        bus.err_clear  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_gray   = '0;
        bus2.err_clear = 1'b0;
        bus2.out_ready = 1'b1;

        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_bin", 32'(bus.out_bin), 32'd0);
        check("rst_out_step_err", 32'(bus.out_step_err), 32'd0);
        check("rst_step_err", 32'(bus.step_err), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_mon_state", 32'(bus.mon_state), 32'(IDLE));
        #11 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Full count sequence including the wrap back to zero.
        lat_on = 1'b1;
        for (int i = 0; i <= 16; i++) send(to_gray(i % 16), 1'b0);
        wait_drain();
        lat_on = 1'b0;

        send(4'b0110, 1'b0);
        send(4'b1000, 1'b0);
        send(4'b1101, 1'b0);
        wait_drain();

        pulse_clear();
        send(4'b0000, 1'b0);
        send(4'b0011, 1'b0);
        send(4'b0010, 1'b0);
        send(4'b1111, 1'b1);
        wait_drain();

        // Backpressure: continuous offer with the consumer stalled.
        ready_mode = 0;
        start = acc_cnt;
        k = 10;
        bus.in_valid = 1'b1;
        bus.in_gray  = to_gray(k);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                k++;
                bus.in_gray = to_gray(k);
            end
        end
        check("bp_accepted", 32'(acc_cnt - start), 32'd2);
        @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_mode = 1;
        wait_drain();

        // Repeats: legal on the main instance, errors on the strict 2-bit-counter instance.
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_gray  = 4'b0101;
            send(4'b0101, 1'b0);
            bus2.in_valid = 1'b0;
        end
        wait_drain();
        repeat (3) @(negedge clk);
        exp_e = 0;
        for (int i = 1; i < 6; i++) if (!AR2) exp_e++;
        check("rep_accepted", 32'(acc2), 32'd6);
        check("rep_out_beats", 32'(out2), 32'd6);
        check("rep_err_beats", 32'(err2), 32'(exp_e));
        check("rep_err_count_sat", 32'(bus2.err_count), 32'((exp_e > CNT2_MAX) ? CNT2_MAX : exp_e));
        check("rep_step_err", 32'(bus2.step_err), 32'(exp_e != 0));
        @(posedge clk);
        #1;

        // Randomized beats: mostly legal steps, some repeats, jumps and clears.
        ready_mode = 2;
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12)      cur = (cur + 1) % 16;
            else if (r < 14) cur = (cur + 15) % 16;
            else if (r < 18 && r >= 16) cur = $urandom_range(0, 15);
            if (r == 19) begin
                @(posedge clk);
                #1;
            end else begin
                send(to_gray(cur), r == 18);
            end
        end
        ready_mode = 1;
        wait_drain();

        // Asynchronous reset with a full pipeline and a raised error flag.
        ready_mode = 0;
        send(4'b0000, 1'b0);
        send(4'b0101, 1'b0);
        #3 rst = 1'b1;
        exp_q.delete();
        stamp_q.delete();
        m_track  = 1'b0;
        m_cnt    = 0;
        m_sticky = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_step_err", 32'(bus.step_err), 32'd0);
        check("midrst_err_count", 32'(bus.err_count), 32'd0);
        check("midrst_mon_state", 32'(bus.mon_state), 32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_no_output", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(4'b0111, 1'b0);
        send(4'b0101, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gray_to_bin_decoder.md
Name: gray_to_bin_decoder

Overview:
- Registered, elastic Gray-to-binary decoder. It is the receive-side counterpart of the team's binary-to-Gray encoder.
- Typical use: consumes Gray-coded counter/pointer values, e.g. from a CDC pointer path.
- Returns binary with a valid/ready handshake.
- Monitors that successive accepted codes differ by exactly one bit. Any jump is flagged as a step error.

Parameters:
- WIDTH, 4, bit width of Gray input and binary output (≥2)
- ALLOW_REPEAT, 1, 1 = an accepted code equal to the previous one is legal; 0 = a repeat is a step error
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  Gray sample present
- in_ready  output  1  block can accept a sample
- in_gray  input  WIDTH  Gray-coded sample
- out_valid  output  1  decoded result present
- out_ready  input  1  downstream accepts the result
- out_bin  output  WIDTH  decoded binary value
- out_step_err  output  1  this result violated the one-bit-step rule
- err_clear  input  1  synchronous clear of error state and tracking history
- step_err  output  1  sticky error flag
- err_count  output  CNT_W  saturating count of step errors

Behaviour:
- Reset (async, active-high) drives all outputs and internal state to 0:
  - out_valid=0, out_bin=0, out_step_err=0, step_err=0, err_count=0.
  - Monitor FSM goes to IDLE.
  - in_ready=1 from the first clock after reset deasserts.
  - Reset mid-operation discards all in-flight beats; no partial output is produced.
- Transfers:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_bin and out_step_err are held stable while out_valid=1 and out_ready=0.
- Two-stage elastic pipeline, latency 2 cycles from accept to out_valid when not stalled; throughput 1 beat/cycle.
  - S1 registers the Gray sample and its step-error bit.
  - S2 registers the decoded binary and the error bit.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational from out_ready. There is no combinational path from in_valid to in_ready.
  - With out_ready=0, the block holds exactly 2 beats, then in_ready=0.
- Decode (combinational between S1 and S2):
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] ^ g[i], for i from WIDTH-2 down to 0.
- Monitor FSM, state IDLE or TRACK, with register prev_gray:
  - IDLE, on accept: prev_gray←in_gray, go to TRACK, beat error bit = 0.
  - TRACK, on accept: d = popcount(in_gray ^ prev_gray).
    - Error if d>1, or if d==0 and ALLOW_REPEAT==0.
    - Then prev_gray←in_gray.
  - An error sets step_err=1 and increments err_count, saturating at 2^CNT_W−1. The beat carries out_step_err=1.
  - Wrap-around, e.g. Gray 1000→0000 for WIDTH=4, is a legal single-bit step.
- err_clear (one cycle):
  - step_err←0, err_count←0, FSM→IDLE.
  - Does not flush the pipeline. Beats already in S1/S2 keep their error bits.
  - Same-cycle err_clear and accept: clear wins. The accepted beat is treated as the IDLE case: it becomes prev_gray, FSM→TRACK, no error, counter stays 0.
- Same-cycle accept and output transfer with a full pipeline: both happen, no bubble.

Decomposition:
- Shared package gray_pkg holds:
  - monitor state enum, mon_state_t {IDLE, TRACK};
  - function gray2bin(WIDTH-generic via parameterised width) for reuse by the bench model.
- One natural sub-module: gray_step_checker. It takes the accept strobe, gray, and err_clear, and returns the beat error bit, step_err, and err_count.
- The pipeline and decode stay in the top module.

Test Plan:
1. Reset with rst=1 mid-stream, pipeline full → out_valid=0, step_err=0, err_count=0 immediately, without waiting for a clock edge. After release, in_ready=1.
2. WIDTH=4, out_ready=1, feed Gray sequence 0000,0001,0011,…,1000 (counts 0–15) then 0000 → out_bin 0..15 then 0 over consecutive cycles, each 2 cycles after accept. out_step_err=0 throughout, err_count=0.
3. Spot decode: in_gray=0110 → out_bin=0100; 1000 → 1111; 1101 → 1001.
4. Step error: accept 0000 then 0011 → second beat out_step_err=1, step_err=1, err_count=1. Next, 0010 is legal (one bit) → out_step_err=0, count stays 1. Pulse err_clear together with accepting 1111 → step_err=0, err_count=0, no error.
5. Backpressure: in_valid=1 continuously, out_ready=0 for 5 cycles → 2 beats accepted, then in_ready=0. out_bin is stable. Raising out_ready drains the beats in order with none lost or duplicated.
6. Repeat and saturation:
   - ALLOW_REPEAT=0, CNT_W=2, feed 0101 six times → 5 errors, err_count saturates at 3.
   - ALLOW_REPEAT=1, same stimulus → no errors.
